// File: rtl/blink_sequencer.sv
// blink_sequencer
// Four-channel indicator sequencer driven by one shared phase counter.
// Each channel is OFF, ON, BLINK or BURST. Configuration writes are taken
// into a single pending slot and applied on a period boundary, so every
// channel changes mode only at the start of a period (p == 0).
//
// Ports
//   clk       system clock, all state changes on its rising edge
//   reset     asynchronous active-high reset
//   wr_en     configuration write strobe (taken only while wr_ready is high)
//   wr_ch     target channel 0..3
//   wr_mode   00 OFF, 01 ON, 10 BLINK, 11 BURST
//   wr_count  burst length in periods (BURST only)
//   wr_ready  high when the pending slot is empty
//   b_en      per-channel indicator enable (registered)
//   busy      per-channel burst in progress (registered)
//   done      per-channel one-cycle burst-complete pulse (registered)
module blink_sequencer #(
   parameter int C_ON         = 2,
   parameter int C_OFF        = 3,
   parameter int C_BITS       = 3,
   parameter int C_BURST_BITS = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [1:0]              wr_ch,
   input  logic [1:0]              wr_mode,
   input  logic [C_BURST_BITS-1:0] wr_count,
   output logic                    wr_ready,
   output logic [3:0]              b_en,
   output logic [3:0]              busy,
   output logic [3:0]              done
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   localparam logic [C_BITS-1:0]       P_LAST  = C_BITS'(C_ON + C_OFF - 1);
   localparam logic [C_BITS-1:0]       P_ON    = C_BITS'(C_ON);
   localparam logic [C_BITS-1:0]       P_ONE   = C_BITS'(1);
   localparam logic [C_BURST_BITS-1:0] CNT_ONE = C_BURST_BITS'(1);

   logic [C_BITS-1:0]       p_q, p_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [1:0]              pend_ch_q, pend_ch_d;
   mode_e                   pend_mode_q, pend_mode_d;
   logic [C_BURST_BITS-1:0] pend_cnt_q, pend_cnt_d;
   mode_e                   mode_q [4];
   mode_e                   mode_d [4];
   logic [C_BURST_BITS-1:0] cnt_q [4];
   logic [C_BURST_BITS-1:0] cnt_d [4];
   logic [3:0]              b_en_q, b_en_d;
   logic [3:0]              busy_q, busy_d;
   logic [3:0]              done_q, done_d;

   logic boundary;
   logic accept;
   logic on_next;

   // Next-state: phase counter, pending slot, per-channel mode/counter and registered outputs.
   always_comb begin
      boundary     = (p_q == P_LAST);
      accept       = wr_en && !pend_valid_q;
      p_d          = boundary ? '0 : (p_q + P_ONE);
      on_next      = (p_d < P_ON);
      pend_valid_d = pend_valid_q;
      pend_ch_d    = pend_ch_q;
      pend_mode_d  = pend_mode_q;
      pend_cnt_d   = pend_cnt_q;
      b_en_d       = 4'b0000;
      busy_d       = 4'b0000;
      done_d       = 4'b0000;

      // Capture and apply never coincide: capture needs an empty slot,
      // apply needs a full one. A slot filled in a boundary cycle is only
      // seen as valid from the next cycle, so it waits a full period.
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_ch_d    = wr_ch;
         pend_mode_d  = mode_e'(wr_mode);
         pend_cnt_d   = wr_count;
      end else if (boundary) begin
         pend_valid_d = 1'b0;
      end else begin
         pend_valid_d = pend_valid_q;
      end

      for (int i = 0; i < 4; i++) begin
         mode_d[i] = mode_q[i];
         cnt_d[i]  = cnt_q[i];
         // An applied write overrides any burst bookkeeping on its channel,
         // even on the burst's final boundary, so no done pulse is raised.
         if (boundary && pend_valid_q && (pend_ch_q == 2'(i))) begin
            case (pend_mode_q)
               MODE_BURST: begin
                  if (pend_cnt_q == '0) begin
                     mode_d[i] = MODE_OFF;
                     cnt_d[i]  = '0;
                  end else begin
                     mode_d[i] = MODE_BURST;
                     cnt_d[i]  = pend_cnt_q;
                  end
               end
               default: begin
                  mode_d[i] = pend_mode_q;
                  cnt_d[i]  = '0;
               end
            endcase
         end else if (boundary && (mode_q[i] == MODE_BURST)) begin
            if (cnt_q[i] <= CNT_ONE) begin
               mode_d[i] = MODE_OFF;
               cnt_d[i]  = '0;
               done_d[i] = 1'b1;
            end else begin
               cnt_d[i]  = cnt_q[i] - CNT_ONE;
            end
         end else begin
            cnt_d[i]  = cnt_q[i];
         end

         // Outputs are computed from next state so they line up with p_q.
         case (mode_d[i])
            MODE_ON:    b_en_d[i] = 1'b1;
            MODE_BLINK: b_en_d[i] = on_next;
            MODE_BURST: b_en_d[i] = on_next;
            default:    b_en_d[i] = 1'b0;
         endcase
         busy_d[i] = (mode_d[i] == MODE_BURST);
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q          <= '0;
         pend_valid_q <= 1'b0;
         pend_ch_q    <= 2'b00;
         pend_mode_q  <= MODE_OFF;
         pend_cnt_q   <= '0;
         b_en_q       <= 4'b0000;
         busy_q       <= 4'b0000;
         done_q       <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            mode_q[i] <= MODE_OFF;
            cnt_q[i]  <= '0;
         end
      end else begin
         p_q          <= p_d;
         pend_valid_q <= pend_valid_d;
         pend_ch_q    <= pend_ch_d;
         pend_mode_q  <= pend_mode_d;
         pend_cnt_q   <= pend_cnt_d;
         b_en_q       <= b_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         for (int i = 0; i < 4; i++) begin
            mode_q[i] <= mode_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   assign wr_ready = !pend_valid_q;
   assign b_en     = b_en_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
